// File: rtl/offchip_pkg.sv
// Shared constants, FSM state type and lane-packing helper for the off-chip link arbiter.
package offchip_pkg;

    localparam int LINK_DEPTH = 8;
    localparam int BEAT_W     = 64;
    localparam int WORD_W     = 32;

    // Byte lanes (MSB first) forming the LO word; the HI word uses the same lanes shifted up by two bytes.
    localparam int LANE_B3     = 5;
    localparam int LANE_B2     = 4;
    localparam int LANE_B1     = 1;
    localparam int LANE_B0     = 0;
    localparam int LANE_HI_OFF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] pack_lanes(input logic [BEAT_W-1:0] d, input logic hi);
        int off;
        off = hi ? LANE_HI_OFF : 0;
        return {d[8*(LANE_B3+off) +: 8], d[8*(LANE_B2+off) +: 8],
                d[8*(LANE_B1+off) +: 8], d[8*(LANE_B0+off) +: 8]};
    endfunction

endpackage

// File: rtl/offchip_rr_pick.sv
// Round-robin picker: searches from last+1 (mod N) and returns a one-hot grant plus its index.
module offchip_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/offchip_link_arb.sv
// Arbitrates 64-bit requester beats onto a credit-managed 32-bit link memory, two writes per beat.
module offchip_link_arb
    import offchip_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DEPTH = LINK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [BEAT_W*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       link_wen,
    output logic [$clog2(DEPTH)-1:0]   link_waddr,
    output logic [WORD_W-1:0]          link_wdata,
    input  logic                       credit_ret,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(N_REQ);

    state_t              state_q, state_d;
    logic [CW-1:0]       credits_q, credits_d;
    logic [AW-1:0]       wptr_q;
    logic [IW-1:0]       grant_q;
    logic                err_q;
    logic [WORD_W-1:0]   hi_word_q;

    logic [N_REQ-1:0]    pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic [BEAT_W-1:0]   win_data;
    logic                accept;
    logic                cred_full;
    logic                cred_inc;

    logic                wen_d;
    logic [AW-1:0]       waddr_d;
    logic [WORD_W-1:0]   wdata_d;

    offchip_rr_pick #(.N(N_REQ)) u_pick (
        .req  (req_valid),
        .last (grant_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign win_data = req_data[BEAT_W*int'(pick_idx) +: BEAT_W];

    // Decision uses registered credits only, so a same-cycle credit_ret cannot enable acceptance.
    assign accept = ((state_q == ST_IDLE) || (state_q == ST_WR_HI)) &&
                    (credits_q >= CW'(2)) && (|req_valid);

    assign req_ready = (accept && !rst) ? pick_gnt : '0;

    assign cred_full = (credits_q == CW'(DEPTH));
    assign cred_inc  = credit_ret && !(cred_full && !accept);
    assign credits_d = credits_q - (accept ? CW'(2) : CW'(0)) + (cred_inc ? CW'(1) : CW'(0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept ? ST_WR_LO : ST_IDLE;
            ST_WR_LO: state_d = ST_WR_HI;
            ST_WR_HI: state_d = accept ? ST_WR_LO : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Link outputs are registered, so they are computed here from the state being entered.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = wptr_q;
        wdata_d = '0;
        case (state_d)
            ST_WR_LO: begin
                wen_d   = 1'b1;
                wdata_d = pack_lanes(win_data, 1'b0);
            end
            ST_WR_HI: begin
                wen_d   = 1'b1;
                wdata_d = hi_word_q;
            end
            default: begin
                wen_d   = 1'b0;
                wdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q  <= CW'(DEPTH);
            wptr_q     <= '0;
            grant_q    <= IW'(N_REQ-1);
            err_q      <= 1'b0;
            hi_word_q  <= '0;
            link_wen   <= 1'b0;
            link_waddr <= '0;
            link_wdata <= '0;
        end else begin
            credits_q <= credits_d;
            if (credit_ret && cred_full && !accept) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                grant_q   <= pick_idx;
                hi_word_q <= pack_lanes(win_data, 1'b1);
            end
            link_wen   <= wen_d;
            link_waddr <= waddr_d;
            link_wdata <= wdata_d;
            if (wen_d) begin
                wptr_q <= wptr_q + AW'(1);
            end
        end
    end

    assign grant_id = grant_q;
    assign credits  = credits_q;
    assign err      = err_q;

endmodule

// File: tb/tb_offchip_link_arb.sv
// Self-checking bench for offchip_link_arb: vector table, directed corner sequences, random vs. queue model.
module tb_offchip_link_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic         link_wen;
    logic [2:0]   link_waddr;
    logic [31:0]  link_wdata;
    logic         credit_ret;
    logic [1:0]   grant_id;
    logic [3:0]   credits;
    logic         err;

    int n_chk = 0;
    int n_err = 0;

    offchip_link_arb #(.N_REQ(4), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .link_wen   (link_wen),
        .link_waddr (link_waddr),
        .link_wdata (link_wdata),
        .credit_ret (credit_ret),
        .grant_id   (grant_id),
        .credits    (credits),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  valid;
        logic        cret;
        logic [3:0]  ready;
        logic        wen;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  cred;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        credit_ret = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] lo_word(input logic [63:0] d);
        return {d[47:40], d[39:32], d[15:8], d[7:0]};
    endfunction

    function automatic logic [31:0] hi_word(input logic [63:0] d);
        return {d[63:56], d[55:48], d[31:24], d[23:16]};
    endfunction

    // reference model state
    int          m_cred, m_last, m_wptr, win;
    bit          m_err, acc, cur_v;
    wr_t         pend[$];
    wr_t         cur;
    bit          rv[4];
    logic [63:0] rd[4];
    logic [3:0]  exp_ready;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        credit_ret = 1'b0;

        tbl[0] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 3'd0, 32'h0,        4'd8};
        tbl[1] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd0, 32'h22336677, 4'd6};
        tbl[2] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd1, 32'h00114455, 4'd6};
        tbl[3] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 3'd0, 32'h0,        4'd6};
        tbl[4] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd2, 32'hAABBEEFF, 4'd5};
        tbl[5] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3'd3, 32'h8899CCDD, 4'd5};
        tbl[6] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd4, 32'h03040708, 4'd3};
        tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd5, 32'h01020506, 4'd3};
        tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 32'h0,        4'd3};

        // reset state
        #3;
        chk("rst_wen", link_wen, 0);
        chk("rst_credits", credits, 8);
        chk("rst_grant", grant_id, 3);
        chk("rst_err", err, 0);
        do_reset();

        // table: single beat, round-robin pickup, accept in WR_HI
        req_data = {64'h0, 64'h0102030405060708, 64'h8899AABBCCDDEEFF, 64'h0011223344556677};
        for (int i = 0; i < 9; i++) begin
            req_valid  = tbl[i].valid;
            credit_ret = tbl[i].cret;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
            chk($sformatf("tbl%0d_wen", i), link_wen, tbl[i].wen);
            chk($sformatf("tbl%0d_cred", i), credits, tbl[i].cred);
            if (tbl[i].wen) begin
                chk($sformatf("tbl%0d_addr", i), link_waddr, tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), link_wdata, tbl[i].data);
            end
            tick();
        end

        // fairness with full credit return, and wptr wrap on the 5th beat
        do_reset();
        req_valid  = 4'b1111;
        credit_ret = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("fair%0d_ready", c), req_ready,
                (c % 2 == 0) ? (64'd1 << ((c / 2) % 4)) : 64'd0);
            if (c >= 1) begin
                chk($sformatf("fair%0d_wen", c), link_wen, 1);
                chk($sformatf("fair%0d_addr", c), link_waddr, (c - 1) % 8);
            end
            tick();
        end
        chk("fair_err", err, 0);

        // credit stall
        do_reset();
        req_valid  = 4'b0001;
        credit_ret = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_ready", c), req_ready, (c % 2 == 0 && c <= 6) ? 1 : 0);
            tick();
        end
        credit_ret = 1'b1;
        @(negedge clk);
        chk("stall_cred0", credits, 0);
        chk("stall_ready_a", req_ready, 0);
        tick();
        credit_ret = 1'b0;
        @(negedge clk);
        chk("stall_cred1", credits, 1);
        chk("stall_ready_b", req_ready, 0);
        tick();
        credit_ret = 1'b1;
        @(negedge clk);
        chk("stall_ready_same_cycle_ret", req_ready, 0);
        tick();
        credit_ret = 1'b0;
        @(negedge clk);
        chk("stall_cred2", credits, 2);
        chk("stall_ready_resume", req_ready, 1);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("stall_cred_after", credits, 0);
        tick();

        // credit_ret coincident with acceptance at credits 4
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c <= 4; c++) begin
            credit_ret = (c == 4);
            @(negedge clk);
            if (c == 4) begin
                chk("simul_cred_before", credits, 4);
                chk("simul_ready", req_ready, 1);
            end
            tick();
        end
        req_valid  = 4'b0000;
        credit_ret = 1'b0;
        @(negedge clk);
        chk("simul_cred_after", credits, 3);
        tick();

        // overflow
        do_reset();
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        @(negedge clk);
        chk("ovf_err", err, 1);
        chk("ovf_cred", credits, 8);
        tick();
        tick();
        @(negedge clk);
        chk("ovf_sticky", err, 1);

        // asynchronous reset in WR_LO drops the beat
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rstlo_wen_before", link_wen, 1);
        req_valid = 4'b1111;
        #2 rst = 1'b1;
        #1;
        chk("rstlo_wen", link_wen, 0);
        chk("rstlo_addr", link_waddr, 0);
        chk("rstlo_data", link_wdata, 0);
        chk("rstlo_ready", req_ready, 0);
        chk("rstlo_cred", credits, 8);
        chk("rstlo_grant", grant_id, 3);
        chk("rstlo_err", err, 0);
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstlo_nohi%0d", c), link_wen, 0);
            tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rstlo_first_grant", req_ready, 1);
        tick();
        req_valid = 4'b0000;

        // randomized run against the queue model
        do_reset();
        m_cred = 8; m_last = 3; m_wptr = 0; m_err = 0; cur_v = 0;
        pend.delete();
        for (int i = 0; i < 4; i++) begin
            rv[i] = 0;
            rd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1;
                    rd[i] = {$urandom, $urandom};
                end
                req_valid[i]         = rv[i];
                req_data[64*i +: 64] = rd[i];
            end
            credit_ret = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = (pend.size() == 0) && (m_cred >= 2) && (rv[0] || rv[1] || rv[2] || rv[3]);
            win = -1;
            if (acc) begin
                for (int k = 1; k <= 4; k++) begin
                    if (win < 0 && rv[(m_last + k) % 4]) win = (m_last + k) % 4;
                end
            end
            exp_ready = acc ? 4'(1 << win) : 4'd0;
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_wen", link_wen, cur_v);
            if (cur_v) begin
                chk("rnd_addr", link_waddr, cur.a);
                chk("rnd_data", link_wdata, cur.d);
            end
            chk("rnd_cred", credits, m_cred);
            chk("rnd_err", err, m_err);
            chk("rnd_grant", grant_id, m_last);
            if (credit_ret) begin
                if (m_cred == 8 && !acc) m_err = 1;
                else m_cred++;
            end
            if (acc) begin
                pend.push_back('{3'(m_wptr), lo_word(rd[win])});
                pend.push_back('{3'((m_wptr + 1) % 8), hi_word(rd[win])});
                m_wptr = (m_wptr + 2) % 8;
                m_cred -= 2;
                m_last = win;
            end
            cur_v = (pend.size() > 0);
            if (cur_v) cur = pend.pop_front();
            tick();
            if (acc) rv[win] = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/offchip_link_arb.md
OFFCHIP_LINK_ARB -- requirements
Module: offchip_link_arb

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter N_REQ, 4, number of 64-bit requesters sharing the off-chip link buffer.
REQ-003 Parameter DEPTH, 8, 32-bit slots in the downstream link memory.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester beat valid.
REQ-007 req_data  in  64*N_REQ  requester i beat at bits [64i+63:64i].
REQ-008 req_ready  out  N_REQ  acceptance strobe, at most one bit high.
REQ-009 link_wen  out  1  link memory write enable.
REQ-010 link_waddr  out  3  link memory write address.
REQ-011 link_wdata  out  32  link memory write data.
REQ-012 credit_ret  in  1  one pulse frees one 32-bit slot.
REQ-013 grant_id  out  2  index of the last accepted requester.
REQ-014 credits  out  4  free slots currently held.
REQ-015 err  out  1  sticky credit-overflow flag.

Function
REQ-016 FSM states SHALL be IDLE, WR_LO and WR_HI.
REQ-017 A beat SHALL be accepted only in IDLE or WR_HI, and only when the registered credits >= 2 and any req_valid is high.
REQ-018 Winner SHALL be chosen round-robin: search starts at grant_id+1 mod N_REQ; req_ready[winner] is high combinationally in the accept cycle.
REQ-019 On acceptance, req_data of the winner and grant_id SHALL be captured, credits reduced by 2, and the state set to WR_LO.
REQ-020 IDLE with no acceptance SHALL remain in IDLE.
REQ-021 WR_LO SHALL drive link_wen=1, link_wdata={d[47:40],d[39:32],d[15:8],d[7:0]}, link_waddr=wptr; wptr+1; next state WR_HI.
REQ-022 WR_HI SHALL drive link_wen=1, link_wdata={d[63:56],d[55:48],d[31:24],d[23:16]}, link_waddr=wptr; wptr+1; next state WR_LO if a beat is accepted, else IDLE.
REQ-023 link_wen, link_waddr and link_wdata SHALL be registered Moore outputs: acceptance at edge t gives the LO write in cycle t+1 and the HI write in cycle t+2.
REQ-024 link_wen SHALL be 0 in IDLE.
REQ-025 Peak throughput SHALL be one beat per 2 cycles.
REQ-026 wptr SHALL be 3 bits and wrap 7->0 without a gap.
REQ-027 Each credit_ret pulse SHALL add 1 to credits.
REQ-028 A credit_ret pulse coinciding with acceptance SHALL give a net change of -1.
REQ-029 credit_ret SHALL NOT affect the same-cycle acceptance decision.
REQ-030 credit_ret while credits==DEPTH with no acceptance SHALL hold credits at DEPTH and set err, which stays set until reset.
REQ-031 With credits < 2, req_ready SHALL stay 0 and requesters SHALL wait; no beat is dropped.
REQ-032 Requesters SHALL hold req_valid and req_data until req_ready; the arbiter does not check this.

Reset
REQ-033 Asserting rst SHALL immediately set: state IDLE, credits DEPTH, wptr 0, grant_id N_REQ-1, err 0, link_wen 0, link_waddr 0, link_wdata 0, req_ready 0.
REQ-034 A beat interrupted by reset (mid WR_LO or WR_HI) SHALL be dropped with no further write.
REQ-035 The first acceptance after release SHALL grant requester 0 if it is valid.

Structure
REQ-036 Shared package offchip_pkg SHALL hold LINK_DEPTH, BEAT_W=64, WORD_W=32, the FSM state enum and the lane-pack constants.
REQ-037 Round-robin selection SHALL be one sub-module offchip_rr_pick (inputs req and last-grant pointer; outputs one-hot grant and index).

Verification
REQ-038 Single beat: req_valid=0001, data 0x0011223344556677 -> ready cycle 0; LO 0x22336677 @addr0 cycle 1; HI 0x00114455 @addr1 cycle 2; credits 6.
REQ-039 Fairness: all four valid continuously -> grants 0,1,2,3,0 at 2-cycle spacing.
REQ-040 Credit stall: 4 beats with no credit_ret -> credits 0 and ready held 0; one credit_ret -> credits 1, still stalled; second pulse -> accept next cycle.
REQ-041 Simultaneous events: credit_ret coincident with acceptance at credits 4 -> credits 3.
REQ-042 Wrap: 5 beats with credit_ret returned -> the 5th beat writes addr 0 and 1.
REQ-043 Overflow and reset: credit_ret at credits 8 -> err=1 and credits 8; rst asserted in WR_LO -> link_wen 0 without waiting for a clock edge, and no HI write follows.
